// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: shares a single-port synchronous-read RAM between the host bus and
// the display scan engine, display first, with a starvation limit that forces host progress.
module fb_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_ack,
    output logic [31:0]       host_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stat_host_stalls
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 2);

    logic              r_host_busy;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [15:0]       r_stat_host_stalls;

    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_s1_host;
    logic              r_s1_disp;

    logic              r_host_ack;
    logic              r_s2_rd;
    logic              r_disp_valid;
    logic [31:0]       r_host_rdata;
    logic [DATA_W-1:0] r_disp_data;

    logic              w_host_pend;
    logic              w_starved;
    logic              w_disp_win;
    logic              w_host_win;
    logic [31:0]       w_rdata_ext;
    logic              w_unused_wdata;

    // Grant terms are gated by the reset input so nothing is accepted while held in reset.
    assign w_host_pend = host_req & ~r_host_busy;
    assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_disp_win  = axi_rst & disp_req & ~(w_host_pend & w_starved);
    assign w_host_win  = axi_rst & w_host_pend & (~disp_req | w_starved);
    assign w_rdata_ext = 32'(ram_rdata);
    assign w_unused_wdata = ^host_wdata;

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            r_host_busy        <= 1'b0;
            r_starve_cnt       <= '0;
            r_stat_host_stalls <= '0;
        end else begin
            if (w_host_win) begin
                r_host_busy <= 1'b1;
            end else if (r_host_ack) begin
                r_host_busy <= 1'b0;
            end

            if (!w_host_pend || w_host_win) begin
                r_starve_cnt <= '0;
            end else if (w_disp_win) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (w_host_pend && w_disp_win && (r_stat_host_stalls != 16'hFFFF)) begin
                r_stat_host_stalls <= r_stat_host_stalls + 16'd1;
            end
        end
    end

    // Stage 1: drive the RAM with the winner of the previous cycle.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_s1_host   <= 1'b0;
            r_s1_disp   <= 1'b0;
        end else begin
            r_ram_en  <= w_disp_win | w_host_win;
            r_s1_host <= w_host_win;
            r_s1_disp <= w_disp_win;
            if (w_host_win) begin
                r_ram_we    <= host_wr;
                r_ram_addr  <= host_addr;
                r_ram_wdata <= host_wdata[DATA_W-1:0];
            end else if (w_disp_win) begin
                r_ram_we   <= 1'b0;
                r_ram_addr <= disp_addr;
            end else begin
                r_ram_we <= 1'b0;
            end
        end
    end

    // Stage 2: response pulses; the hold registers keep the last delivered data between pulses.
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            r_host_ack   <= 1'b0;
            r_s2_rd      <= 1'b0;
            r_disp_valid <= 1'b0;
            r_host_rdata <= '0;
            r_disp_data  <= '0;
        end else begin
            r_host_ack   <= r_s1_host;
            r_s2_rd      <= r_s1_host & ~r_ram_we;
            r_disp_valid <= r_s1_disp;
            if (r_host_ack && r_s2_rd) begin
                r_host_rdata <= w_rdata_ext;
            end
            if (r_disp_valid) begin
                r_disp_data <= ram_rdata;
            end
        end
    end

    assign disp_gnt         = w_disp_win;
    assign ram_en           = r_ram_en;
    assign ram_we           = r_ram_we;
    assign ram_addr         = r_ram_addr;
    assign ram_wdata        = r_ram_wdata;
    assign host_ack         = r_host_ack;
    assign disp_valid       = r_disp_valid;
    assign stat_host_stalls = r_stat_host_stalls;
    // RAM data arrives in the response cycle, so it is forwarded directly during the pulse.
    assign host_rdata       = (r_host_ack && r_s2_rd) ? w_rdata_ext : r_host_rdata;
    assign disp_data        = r_disp_valid ? ram_rdata : r_disp_data;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural synchronous-read RAM; expected values are
// hand-derived from the preloaded pattern mem[a] = 0xA00000 | a.
module tb_fb_arbiter;

    logic        axi_clk;
    logic        axi_rst;
    logic        host_req;
    logic        host_wr;
    logic [10:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        disp_gnt;
    logic        disp_valid;
    logic [23:0] disp_data;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata;
    logic [15:0] stat_host_stalls;

    int n_checks;
    int n_errors;

    logic [23:0] mem [2048];

    fb_arbiter #(
        .ADDR_W    (11),
        .DATA_W    (24),
        .STARVE_MAX(8)
    ) u_dut (
        .axi_clk         (axi_clk),
        .axi_rst         (axi_rst),
        .host_req        (host_req),
        .host_wr         (host_wr),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .disp_req        (disp_req),
        .disp_addr       (disp_addr),
        .disp_gnt        (disp_gnt),
        .disp_valid      (disp_valid),
        .disp_data       (disp_data),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .stat_host_stalls(stat_host_stalls)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    always @(posedge axi_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    initial begin
        logic exp_en  [6];
        logic exp_ack [6];
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 24'hA00000 | 24'(i);

        axi_rst    = 1'b0;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        disp_req   = 1'b1;
        disp_addr  = '0;

        // Reset state, with a display request held to prove the grant is gated.
        tick();
        tick();
        check("rst_disp_gnt", 32'(disp_gnt), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_disp_data", 32'(disp_data), 0);
        check("rst_stat", 32'(stat_host_stalls), 0);
        disp_req = 1'b0;
        tick();
        axi_rst = 1'b1;
        tick();
        tick();

        // Lone host read of 0x005.
        host_req = 1'b1; host_wr = 1'b0; host_addr = 11'h005;
        #1 check("rd_no_disp_gnt", 32'(disp_gnt), 0);
        tick();
        check("rd_ram_en", 32'(ram_en), 1);
        check("rd_ram_we", 32'(ram_we), 0);
        check("rd_ram_addr", 32'(ram_addr), 32'h005);
        tick();
        check("rd_ack", 32'(host_ack), 1);
        check("rd_rdata", host_rdata, 32'h00A00005);
        host_req = 1'b0;
        tick();
        check("rd_ack_low", 32'(host_ack), 0);
        check("rd_rdata_hold", host_rdata, 32'h00A00005);
        check("rd_ram_idle", 32'(ram_en), 0);

        // Held host_req: grants at G and G+3 only, acks never adjacent.
        exp_en  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        host_req = 1'b1; host_addr = 11'h007;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("hold_en_c%0d", c), 32'(ram_en), 32'(exp_en[c-1]));
            check($sformatf("hold_ack_c%0d", c), 32'(host_ack), 32'(exp_ack[c-1]));
            if (c == 5) begin
                check("hold_rdata", host_rdata, 32'h00A00007);
                host_req = 1'b0;
            end
        end

        // Host write to 0x010, then display read of 0x010 the next cycle.
        tick();
        host_req = 1'b1; host_wr = 1'b1; host_addr = 11'h010; host_wdata = 32'h12ABCDEF;
        tick();
        check("wr_ram_en", 32'(ram_en), 1);
        check("wr_ram_we", 32'(ram_we), 1);
        check("wr_ram_addr", 32'(ram_addr), 32'h010);
        check("wr_ram_wdata", 32'(ram_wdata), 32'h00ABCDEF);
        disp_req = 1'b1; disp_addr = 11'h010;
        #1 check("wr_disp_gnt", 32'(disp_gnt), 1);
        tick();
        check("wr_ack", 32'(host_ack), 1);
        check("wr_rdata_hold", host_rdata, 32'h00A00007);
        check("dr_ram_we", 32'(ram_we), 0);
        check("dr_ram_addr", 32'(ram_addr), 32'h010);
        host_req = 1'b0; host_wr = 1'b0; disp_req = 1'b0;
        tick();
        check("dr_valid", 32'(disp_valid), 1);
        check("dr_data", 32'(disp_data), 32'h00ABCDEF);
        tick();
        check("dr_valid_low", 32'(disp_valid), 0);
        check("dr_data_hold", 32'(disp_data), 32'h00ABCDEF);

        // Starvation: 8 display grants, host forced on the 9th, display resumes.
        disp_req = 1'b1; disp_addr = 11'h020;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 11'h030;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 9) begin
                check("st_ram_en", 32'(ram_en), 1);
                check("st_ram_we", 32'(ram_we), 0);
                check("st_ram_addr", 32'(ram_addr), 32'h030);
            end
            if (c == 10) begin
                check("st_ack", 32'(host_ack), 1);
                check("st_rdata", host_rdata, 32'h00A00030);
                check("st_stalls", 32'(stat_host_stalls), 8);
                host_req = 1'b0;
            end
            #1 check($sformatf("st_gnt_c%0d", c), 32'(disp_gnt), (c == 8) ? 0 : 1);
        end
        disp_req = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // Display streaming 0..15, one valid per cycle in order, latency 2.
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) tick();
            check($sformatf("sm_valid_c%0d", c), 32'(disp_valid),
                  (c >= 2 && c < 18) ? 1 : 0);
            if (c >= 2 && c < 18)
                check($sformatf("sm_data_c%0d", c), 32'(disp_data),
                      32'h00A00000 | 32'(c - 2));
            disp_req  = (c < 16);
            disp_addr = 11'(c);
            #1 if (c < 16) check($sformatf("sm_gnt_c%0d", c), 32'(disp_gnt), 1);
        end
        disp_req = 1'b0;
        tick();

        // Reset asserted at G+1 of a host read.
        host_req = 1'b1; host_wr = 1'b0; host_addr = 11'h005;
        tick();
        check("mr_ram_en_pre", 32'(ram_en), 1);
        axi_rst = 1'b0;
        disp_req = 1'b1;
        #1;
        check("mr_ram_en", 32'(ram_en), 0);
        check("mr_disp_gnt", 32'(disp_gnt), 0);
        check("mr_host_rdata", host_rdata, 0);
        check("mr_disp_data", 32'(disp_data), 0);
        check("mr_stat", 32'(stat_host_stalls), 0);
        host_req = 1'b0;
        disp_req = 1'b0;
        tick();
        tick();
        axi_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("mr_no_ack_c%0d", c), 32'(host_ack), 0);
            check($sformatf("mr_no_en_c%0d", c), 32'(ram_en), 0);
        end
        host_req = 1'b1; host_addr = 11'h006;
        tick();
        check("mr_fresh_en", 32'(ram_en), 1);
        check("mr_fresh_addr", 32'(ram_addr), 32'h006);
        tick();
        check("mr_fresh_ack", 32'(host_ack), 1);
        check("mr_fresh_rdata", host_rdata, 32'h00A00006);
        host_req = 1'b0;
        tick();
        check("mr_fresh_ack_low", 32'(host_ack), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Arbitrates a single-port, synchronous-read frame-buffer RAM between two requesters: the host local bus (from the AXI4-Lite slave) and the display scan engine.
- Display has priority.
- A starvation limit guarantees the host progress.
- It issues at most one RAM access per cycle and is fully pipelined.
- It sits between the AXI4-Lite slave, the display driver and the frame-buffer RAM. It replaces the dual-port distributed RAM arrangement so the frame buffer can map to block RAM.

Parameters:
ADDR_W, 11, RAM word-address width
DATA_W, 24, RAM data width (RGB888)
STARVE_MAX, 8, max consecutive display grants while host pending before host is forced

Ports:
axi_clk  in  1  clock
axi_rst  in  1  asynchronous active-low reset
host_req  in  1  host access request, level, held until host_ack
host_wr  in  1  1=write, 0=read; stable while host_req
host_addr  in  ADDR_W  host word address
host_wdata  in  32  write data; bits [DATA_W-1:0] stored
host_ack  out  1  one-cycle completion pulse
host_rdata  out  32  read data, zero-extended; valid with host_ack
disp_req  in  1  display read request, level
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  combinational accept; requester may advance address next cycle
disp_valid  out  1  one-cycle pulse, disp_data valid
disp_data  out  DATA_W  display read data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, one-cycle latency after ram_en
stat_host_stalls  out  16  saturating count of host-stalled cycles

Behaviour:
- Reset (axi_rst=0, async): all registered outputs 0, in-flight transactions discarded, starvation counter 0, host_busy 0. disp_gnt is 0 because its inputs are gated by reset.
- Host pending: host_pend = host_req & !host_busy.
- Arbitration, evaluated each cycle G from current inputs and registered state:
  - Only disp_req: display granted.
  - Only host_pend: host granted.
  - Both, starve_cnt < STARVE_MAX: display granted, starve_cnt++.
  - Both, starve_cnt == STARVE_MAX: host granted, disp_gnt=0 (display holds req).
  - Neither: idle; ram_en=0 in G+1.
- starve_cnt clears on any host grant or any cycle with host_pend=0.
- Pipeline, for a grant in cycle G:
  - G+1: ram_en=1, ram_addr/ram_we/ram_wdata registered from the winner. ram_we=1 only for host write.
  - G+2: host_ack or disp_valid pulses for one cycle, with data registered from ram_rdata.
- Fixed latency of 2 cycles from grant to response, for reads and writes.
- Back-to-back display grants every cycle give one disp_valid per cycle, in grant order.
- host_busy:
  - Set at host grant.
  - Cleared at the end of the host_ack cycle. No regrant of a held host_req until G+3.
  - Only one host transaction is in flight.
- Host write: host_rdata holds its previous value. host_ack still pulses at G+2.
- Ordering: a write granted in G followed by a read of the same address granted in G+1 returns the new data.
- stat_host_stalls increments in every cycle with host_pend=1 and display granted, saturating at 0xFFFF.
- disp_data and host_rdata hold their last values between pulses.
- Changing host_addr, host_wr or host_wdata while host_busy is undefined usage; the arbiter uses values sampled at grant.
- Reset asserted mid-transaction: no ack/valid is ever produced for that transaction.

Test Plan:
- Reset → all outputs 0. Host read of addr 0x005 alone → ram_en=1, ram_we=0, ram_addr=0x005 at G+1. host_ack at G+2 with host_rdata = {8'h0, ram_rdata}.
- Host write 0x12ABCDEF to 0x010, then display read of 0x010 next cycle → ram_wdata=0xABCDEF. disp_valid 2 cycles after disp_gnt with disp_data=0xABCDEF.
- disp_req held high continuously plus host read pending, STARVE_MAX=8 → 8 display grants, then host granted on the 9th cycle (disp_gnt=0), display resumes the next cycle. stat_host_stalls=8.
- Display streaming addr 0..15 every cycle, no host → 16 consecutive disp_valid pulses with data in address order, no gaps, latency 2.
- Host holds host_req across ack → exactly one grant per transaction. Next grant no earlier than G+3. host_ack is never two cycles in a row.
- axi_rst asserted at G+1 of a host read → no host_ack after release. Outputs 0 during reset. A fresh request after release completes normally.
